// File: rtl/rv32i_writeback.sv
// rv32i_writeback
//
// Final pipeline stage of the rv32i core, fed by the memory-access stage.
// Registers that stage's outputs, aligns and extends load data according to
// func3 and the address low bits, drives the single register-file write
// port, flags misaligned loads and keeps a 64-bit retired-instruction count.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   i_ce                upstream stage holds a valid instruction
//   i_stall, i_flush    pipeline stall / flush (passed through on o_stall/o_flush)
//   i_opcode            one-hot opcode; bit L_TYPE marks loads
//   i_func3             load size / sign select
//   i_wr_rd, i_rd_addr  instruction writes rd / destination register
//   i_rd_val            ALU result for non-load instructions
//   i_data_load         raw word from data memory
//   i_addr_lsb          low two bits of the load address
//   i_pc                instruction PC
//   o_wr_en/addr/data   register-file write port (o_wr_en is a 1-cycle pulse)
//   o_ce                stage holds a retired instruction this cycle
//   o_pc                PC of the instruction in this stage
//   o_misaligned        1-cycle pulse: a misaligned load was suppressed
//   o_instret           retired-instruction count, wraps modulo 2^64
//   o_stall, o_flush    combinational copies of i_stall / i_flush
module rv32i_writeback #(
    parameter int OPCODE_WIDTH = 11,
    parameter int L_TYPE       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_ce,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]              i_func3,
    input  logic                    i_wr_rd,
    input  logic [4:0]              i_rd_addr,
    input  logic [31:0]             i_rd_val,
    input  logic [31:0]             i_data_load,
    input  logic [1:0]              i_addr_lsb,
    input  logic [31:0]             i_pc,
    output logic                    o_wr_en,
    output logic [4:0]              o_wr_addr,
    output logic [31:0]             o_wr_data,
    output logic                    o_ce,
    output logic [31:0]             o_pc,
    output logic                    o_misaligned,
    output logic [63:0]             o_instret,
    output logic                    o_stall,
    output logic                    o_flush
);

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    logic        adv;
    logic        is_load;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    logic        misaligned;

    // Only the load bit of the opcode matters here; the rest is folded into
    // a sink so the bus can stay full width.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^i_opcode;

    assign adv     = i_ce && !i_stall && !i_flush;
    assign is_load = i_opcode[L_TYPE];

    // This stage never stalls on its own.
    assign o_stall = i_stall;
    assign o_flush = i_flush;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        byte_sel   = i_data_load[7:0];
        half_sel   = i_addr_lsb[1] ? i_data_load[31:16] : i_data_load[15:0];
        result     = i_rd_val;
        misaligned = 1'b0;

        case (i_addr_lsb)
            2'd1:    byte_sel = i_data_load[15:8];
            2'd2:    byte_sel = i_data_load[23:16];
            2'd3:    byte_sel = i_data_load[31:24];
            default: byte_sel = i_data_load[7:0];
        endcase

        if (is_load) begin
            case (i_func3)
                F3_LB:  result = {{24{byte_sel[7]}}, byte_sel};
                F3_LBU: result = {24'd0, byte_sel};
                F3_LH: begin
                    result     = {{16{half_sel[15]}}, half_sel};
                    misaligned = i_addr_lsb[0];
                end
                F3_LHU: begin
                    result     = {16'd0, half_sel};
                    misaligned = i_addr_lsb[0];
                end
                F3_LW: begin
                    result     = i_data_load;
                    misaligned = (i_addr_lsb != 2'd0);
                end
                // Unlisted codes take the word path with no alignment check.
                default: result = i_data_load;
            endcase
        end
    end

    // NOTE: all state is cleared by the asynchronous reset; the stage holds
    // no memory arrays, so every register can take a reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_wr_en      <= 1'b0;
            o_wr_addr    <= 5'd0;
            o_wr_data    <= 32'd0;
            o_ce         <= 1'b0;
            o_pc         <= 32'd0;
            o_misaligned <= 1'b0;
            o_instret    <= 64'd0;
        end else if (adv) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            o_wr_addr    <= i_rd_addr;
            o_wr_data    <= result;
            o_pc         <= i_pc;
            o_ce         <= 1'b1;
            o_wr_en      <= i_wr_rd && (i_rd_addr != 5'd0) && !misaligned;
            o_misaligned <= misaligned;
            if (!misaligned) begin
                o_instret <= o_instret + 64'd1;
            end
        end else begin
            // Stall, flush or bubble: strobes drop so a held instruction is
            // written only once, when it finally advances.
            o_wr_en      <= 1'b0;
            o_misaligned <= 1'b0;
            o_ce         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_writeback.sv
module tb_rv32i_writeback;

    localparam int OPCODE_WIDTH = 11;
    localparam int L_TYPE       = 1;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD = 11'h002;
    localparam logic [OPCODE_WIDTH-1:0] OP_ALU  = 11'h010;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    i_ce, i_stall, i_flush;
    logic [OPCODE_WIDTH-1:0] i_opcode;
    logic [2:0]              i_func3;
    logic                    i_wr_rd;
    logic [4:0]              i_rd_addr;
    logic [31:0]             i_rd_val, i_data_load, i_pc;
    logic [1:0]              i_addr_lsb;
    logic                    o_wr_en, o_ce, o_misaligned, o_stall, o_flush;
    logic [4:0]              o_wr_addr;
    logic [31:0]             o_wr_data, o_pc;
    logic [63:0]             o_instret;

    rv32i_writeback #(.OPCODE_WIDTH(OPCODE_WIDTH), .L_TYPE(L_TYPE)) dut (
        .clk(clk), .reset(reset), .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
        .i_opcode(i_opcode), .i_func3(i_func3), .i_wr_rd(i_wr_rd), .i_rd_addr(i_rd_addr),
        .i_rd_val(i_rd_val), .i_data_load(i_data_load), .i_addr_lsb(i_addr_lsb), .i_pc(i_pc),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_ce(o_ce),
        .o_pc(o_pc), .o_misaligned(o_misaligned), .o_instret(o_instret),
        .o_stall(o_stall), .o_flush(o_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [2:0]  f3;
        logic        wr_rd;
        logic [4:0]  rd;
        logic [31:0] rd_val;
        logic [31:0] data;
        logic [1:0]  lsb;
        logic [31:0] pc;
        logic        e_wr_en;
        logic [31:0] e_data;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic        wr_en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic        mis;
        logic [63:0] instret;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    logic [63:0] exp_instret = 64'd0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v, input bit ce, input bit stall, input bit flush);
        @(posedge clk);
        #1;
        i_ce        = ce;
        i_stall     = stall;
        i_flush     = flush;
        i_opcode    = v.load ? OP_LOAD : OP_ALU;
        i_func3     = v.f3;
        i_wr_rd     = v.wr_rd;
        i_rd_addr   = v.rd;
        i_rd_val    = v.rd_val;
        i_data_load = v.data;
        i_addr_lsb  = v.lsb;
        i_pc        = v.pc;
    endtask

    // Presents an instruction that will advance and records its expected result.
    task automatic op(input vec_t v);
        exp_t e;
        drive(v, 1'b1, 1'b0, 1'b0);
        if (!v.e_mis) exp_instret = exp_instret + 64'd1;
        e.wr_en   = v.e_wr_en;
        e.addr    = v.rd;
        e.data    = v.e_data;
        e.pc      = v.pc;
        e.mis     = v.e_mis;
        e.instret = exp_instret;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, {63'd0, o_wr_en}, 64'd0);
        check({tag, "_wr_addr"}, {59'd0, o_wr_addr}, 64'd0);
        check({tag, "_wr_data"}, {32'd0, o_wr_data}, 64'd0);
        check({tag, "_ce"}, {63'd0, o_ce}, 64'd0);
        check({tag, "_pc"}, {32'd0, o_pc}, 64'd0);
        check({tag, "_mis"}, {63'd0, o_misaligned}, 64'd0);
        check({tag, "_instret"}, o_instret, 64'd0);
    endtask

    // Monitor: every retired instruction is matched against the scoreboard;
    // idle cycles must carry no write or misalignment strobe.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_ce) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", {63'd0, o_ce}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_en", {63'd0, o_wr_en}, {63'd0, e.wr_en});
                    check("wr_addr", {59'd0, o_wr_addr}, {59'd0, e.addr});
                    check("wr_data", {32'd0, o_wr_data}, {32'd0, e.data});
                    check("pc", {32'd0, o_pc}, {32'd0, e.pc});
                    check("misaligned", {63'd0, o_misaligned}, {63'd0, e.mis});
                    check("instret", o_instret, e.instret);
                end
            end else begin
                check("idle_wr_en", {63'd0, o_wr_en}, 64'd0);
                check("idle_misaligned", {63'd0, o_misaligned}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset = 1'b1;
        i_ce = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_opcode = '0; i_func3 = '0; i_wr_rd = 1'b0; i_rd_addr = '0;
        i_rd_val = '0; i_data_load = '0; i_addr_lsb = '0; i_pc = '0;
        #3;
        check_all_zero("reset");
        #20;
        reset = 1'b0;

        //                load  f3      wr    rd     rd_val        data          lsb    pc          wr_en data          mis
        tbl.push_back('{1'b1, 3'b000, 1'b1, 5'd5,  32'hDEADBEEF, 32'h80FF1234, 2'd3, 32'h100, 1'b1, 32'hFFFFFF80, 1'b0}); // LB
        tbl.push_back('{1'b1, 3'b101, 1'b1, 5'd6,  32'h0,        32'h80017FFF, 2'd2, 32'h104, 1'b1, 32'h00008001, 1'b0}); // LHU
        tbl.push_back('{1'b1, 3'b001, 1'b1, 5'd6,  32'h0,        32'h80017FFF, 2'd0, 32'h108, 1'b1, 32'h00007FFF, 1'b0}); // LH
        tbl.push_back('{1'b1, 3'b001, 1'b1, 5'd8,  32'h0,        32'h80017FFF, 2'd2, 32'h10C, 1'b1, 32'hFFFF8001, 1'b0}); // LH upper
        tbl.push_back('{1'b1, 3'b000, 1'b1, 5'd9,  32'h0,        32'h80FF1234, 2'd1, 32'h110, 1'b1, 32'h00000012, 1'b0}); // LB
        tbl.push_back('{1'b1, 3'b100, 1'b1, 5'd10, 32'h0,        32'h80FF1234, 2'd2, 32'h114, 1'b1, 32'h000000FF, 1'b0}); // LBU
        tbl.push_back('{1'b1, 3'b010, 1'b1, 5'd11, 32'h0,        32'hCAFEF00D, 2'd0, 32'h118, 1'b1, 32'hCAFEF00D, 1'b0}); // LW
        tbl.push_back('{1'b1, 3'b010, 1'b1, 5'd7,  32'h0,        32'hCAFEF00D, 2'd2, 32'h11C, 1'b0, 32'hCAFEF00D, 1'b1}); // LW misaligned
        tbl.push_back('{1'b1, 3'b001, 1'b1, 5'd12, 32'h0,        32'h80017FFF, 2'd1, 32'h120, 1'b0, 32'h00007FFF, 1'b1}); // LH misaligned
        tbl.push_back('{1'b1, 3'b011, 1'b1, 5'd13, 32'h0,        32'h12345678, 2'd2, 32'h124, 1'b1, 32'h12345678, 1'b0}); // unlisted f3
        tbl.push_back('{1'b0, 3'b000, 1'b1, 5'd0,  32'h12345678, 32'hFFFFFFFF, 2'd3, 32'h128, 1'b0, 32'h12345678, 1'b0}); // ALU x0
        tbl.push_back('{1'b0, 3'b000, 1'b0, 5'd14, 32'hA5A5A5A5, 32'h0,        2'd0, 32'h12C, 1'b0, 32'hA5A5A5A5, 1'b0}); // ALU no wr
        tbl.push_back('{1'b0, 3'b010, 1'b1, 5'd15, 32'h0BADF00D, 32'h0,        2'd1, 32'h130, 1'b1, 32'h0BADF00D, 1'b0}); // ALU, lsb!=0
        tbl.push_back('{1'b1, 3'b100, 1'b1, 5'd16, 32'h0,        32'h80FF1234, 2'd3, 32'h134, 1'b1, 32'h00000080, 1'b0}); // LBU

        foreach (tbl[i]) op(tbl[i]);
        drive(tbl[0], 1'b0, 1'b0, 1'b0);

        // Stall for three cycles, then release: exactly one write.
        v = '{1'b1, 3'b000, 1'b1, 5'd20, 32'h0, 32'h000000AB, 2'd0, 32'h200, 1'b1, 32'hFFFFFFAB, 1'b0};
        drive(v, 1'b1, 1'b1, 1'b0);
        #1 check("o_stall_pass", {63'd0, o_stall}, 64'd1);
        drive(v, 1'b1, 1'b1, 1'b0);
        drive(v, 1'b1, 1'b1, 1'b0);
        op(v);
        drive(v, 1'b0, 1'b0, 1'b0);
        drive(v, 1'b0, 1'b0, 1'b0);

        // Flush with stall, then flush alone: instruction discarded.
        v.pc = 32'h204;
        drive(v, 1'b1, 1'b1, 1'b1);
        #1 check("o_flush_pass", {63'd0, o_flush}, 64'd1);
        drive(v, 1'b1, 1'b0, 1'b1);
        drive(v, 1'b0, 1'b0, 1'b0);
        #1 check("o_flush_clear", {63'd0, o_flush}, 64'd0);
        drive(v, 1'b0, 1'b0, 1'b0);

        // Reset asserted between edges during a write stream.
        v = '{1'b0, 3'b000, 1'b1, 5'd21, 32'h11111111, 32'h0, 2'd0, 32'h300, 1'b1, 32'h11111111, 1'b0};
        op(v);
        v.rd = 5'd22; v.rd_val = 32'h22222222; v.e_data = 32'h22222222; v.pc = 32'h304;
        op(v);
        v.rd = 5'd23; v.rd_val = 32'h33333333; v.e_data = 32'h33333333; v.pc = 32'h308;
        op(v);
        #1;
        reset = 1'b1;
        sb.delete();
        exp_instret = 64'd0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        check("midreset_hold_wr_en", {63'd0, o_wr_en}, 64'd0);
        check("midreset_hold_ce", {63'd0, o_ce}, 64'd0);
        i_ce = 1'b0;
        reset = 1'b0;

        // First instruction after reset is processed normally.
        v = '{1'b1, 3'b010, 1'b1, 5'd24, 32'h0, 32'h0F0F0F0F, 2'd0, 32'h400, 1'b1, 32'h0F0F0F0F, 1'b0};
        op(v);
        drive(v, 1'b0, 1'b0, 1'b0);
        drive(v, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
